sram_mp_arbiter: RTL and testbench
==================================

Name: sram_mp_arbiter

Overview:
- Multi-channel successor to the single-port SRAM front end.
- Arbitrates NUM_CH independent requesters, each with a read/write request, onto one single-port SRAM macro interface.
- Supports round-robin or fixed priority, configurable SRAM read latency, full one-access-per-cycle throughput, and per-channel read-response routing and write-done routing.
- Sits between the CXL-SSD host/datapath engines and the shared on-chip buffer SRAM.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- DATA_WIDTH, 128, data width in bits.
- MAX_ADDR, 128, number of SRAM words.
- ADDR_BIT_WIDTH, $clog2(MAX_ADDR), address width.
- RD_LATENCY, 1, cycles from SRAM pins sampled with a read to i_sram_rdata valid (1..4).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_CH  per-channel access request, level.
- i_we  in  NUM_CH  per-channel 1 = write, 0 = read.
- i_addr  in  NUM_CH*ADDR_BIT_WIDTH  per-channel address, channel c at [c*AW +: AW].
- i_wdata  in  NUM_CH*DATA_WIDTH  per-channel write data.
- o_gnt  out  NUM_CH  one-hot, combinational; request accepted this cycle.
- o_rvalid  out  NUM_CH  one-hot, registered; read data valid for that channel.
- o_rdata  out  DATA_WIDTH  shared read-data bus, qualified by o_rvalid.
- o_wdone  out  NUM_CH  one-hot, registered; write issued to the SRAM.
- o_err  out  NUM_CH  registered; out-of-range access, pulses with o_rvalid or o_wdone.
- o_busy  out  1  registered; reads outstanding in the response pipeline.
- o_sram_cs_n  out  1  SRAM chip select, active-low, registered.
- o_sram_we_n  out  1  SRAM write enable, active-low, registered.
- o_sram_addr  out  ADDR_BIT_WIDTH  SRAM address, registered.
- o_sram_wdata  out  DATA_WIDTH  SRAM write data, registered.
- i_sram_rdata  in  DATA_WIDTH  SRAM read data.

Behaviour:
- Reset state: o_sram_cs_n = 1, o_sram_we_n = 1, o_sram_addr = 0, o_sram_wdata = 0, o_rdata = 0. All of o_rvalid, o_wdone, o_err, o_busy = 0. Round-robin pointer = 0.
- Reset mid-operation: in-flight reads are discarded; no o_rvalid appears after reset is released.
- Arbitration (cycle T): combinational over i_req.
  - Round-robin: search starts at the pointer and wraps modulo NUM_CH. On any grant to channel g, the pointer becomes (g+1) mod NUM_CH; otherwise it holds.
  - Fixed priority: the lowest-index requester wins.
  - At most one o_gnt bit is set. o_gnt[c] is only set when i_req[c] = 1.
- Handshake: the requester holds i_req/i_we/i_addr/i_wdata stable until o_gnt. The access is accepted in the cycle where both are high. The requester may keep i_req high for back-to-back accesses; each o_gnt cycle is one access.
- Issue (T+1): the registered SRAM pins carry the granted access.
  - Write: cs_n = 0, we_n = 0, addr, wdata. o_wdone[g] = 1 for 1 cycle.
  - Read: cs_n = 0, we_n = 1, addr.
  - No grant: cs_n = 1, we_n = 1. addr and wdata hold their previous values.
- Read return: i_sram_rdata is sampled at T+1+RD_LATENCY. o_rdata and o_rvalid[g] are registered at T+2+RD_LATENCY, so total latency is RD_LATENCY+2 cycles from o_gnt.
  - Channel id and valid travel in a shift pipeline of depth RD_LATENCY+1.
  - o_rdata holds its last value when o_rvalid = 0.
- Throughput: one access per cycle with no bubbles. Reads and writes to different or the same channels interleave freely.
- Read-after-write ordering: a read to the same address granted the cycle after a write returns the new data, because SRAM order equals grant order.
- Out-of-range address (addr >= MAX_ADDR, only possible when MAX_ADDR is not a power of 2):
  - The access is still granted, but cs_n stays 1.
  - Read: returns o_rdata = 0 with o_rvalid and o_err at the normal latency.
  - Write: dropped; o_wdone and o_err pulse at T+1.
- o_busy = OR of the read-pipeline valid bits.
- Simultaneous o_rvalid for one channel and o_wdone for another in the same cycle is legal.

Test Plan:
1. Reset, idle, RD_LATENCY = 1: all outputs hold their reset values. Write ch0 addr 5 data 0xA5, then read ch0 addr 5 → o_gnt[0] = 1 in the request cycle; o_wdone[0] at +1; o_rvalid[0] with o_rdata = 0xA5 exactly 3 cycles after the read grant.
2. Round-robin, NUM_CH = 4, all four i_req held high with reads → o_gnt order 0,1,2,3,0,…, one per cycle. o_rvalid follows the same order with no gaps.
3. ARB_MODE = 1, ch1 and ch3 requesting continuously → ch1 is always granted and ch3 is starved. Dropping ch1 lets ch3 be granted the next cycle.
4. RD_LATENCY = 3, back-to-back reads ch2 addr 1, 2, 3 preloaded with 0x11/0x22/0x33 → o_rvalid[2] on 3 consecutive cycles with data 0x11, 0x22, 0x33, each 5 cycles after its grant.
5. Assert i_rst_n low while 2 reads are in flight → o_busy drops to 0 immediately and no o_rvalid is seen after release. The next read returns correct data.
6. MAX_ADDR = 100, ch1 reads addr 120 → o_sram_cs_n stays 1; o_rvalid[1], o_err[1] and o_rdata = 0 at grant+3.

Source files
------------

// File: rtl/sram_mp_arbiter.sv
// ---------------------------------------------------------------------------
// sram_mp_arbiter
//   Multi-channel front end that shares one single-port SRAM macro between
//   NUM_CH requesters. Each cycle at most one request is granted (round-robin
//   or fixed priority), driven onto registered SRAM pins the next cycle, and
//   read data is routed back to the requesting channel RD_LATENCY+2 cycles
//   after the grant.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req/i_we              per-channel request level and write flag
//   i_addr/i_wdata          per-channel address/data, channel c at [c*W +: W]
//   o_gnt                   one-hot combinational grant (access accepted)
//   o_rvalid/o_rdata        registered one-hot read valid + shared data bus
//   o_wdone                 registered one-hot write-issued pulse
//   o_err                   registered out-of-range flag, pulses with
//                           o_rvalid or o_wdone of the same channel
//   o_busy                  reads outstanding in the response pipeline
//   o_sram_*                registered SRAM macro pins (cs_n/we_n active-low)
//   i_sram_rdata            SRAM read data
// ---------------------------------------------------------------------------
module sram_mp_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 128,
    parameter int MAX_ADDR       = 128,
    parameter int ADDR_BIT_WIDTH = $clog2(MAX_ADDR),
    parameter int RD_LATENCY     = 1,
    parameter int ARB_MODE       = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_CH-1:0]                i_req,
    input  logic [NUM_CH-1:0]                i_we,
    input  logic [NUM_CH*ADDR_BIT_WIDTH-1:0] i_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     i_wdata,
    output logic [NUM_CH-1:0]                o_gnt,
    output logic [NUM_CH-1:0]                o_rvalid,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic [NUM_CH-1:0]                o_wdone,
    output logic [NUM_CH-1:0]                o_err,
    output logic                             o_busy,
    output logic                             o_sram_cs_n,
    output logic                             o_sram_we_n,
    output logic [ADDR_BIT_WIDTH-1:0]        o_sram_addr,
    output logic [DATA_WIDTH-1:0]            o_sram_wdata,
    input  logic [DATA_WIDTH-1:0]            i_sram_rdata
);

    localparam int AW  = ADDR_BIT_WIDTH;
    localparam int CW  = $clog2(NUM_CH);
    localparam int CWP = CW + 1;
    localparam int AWP = AW + 1;
    localparam logic [CW:0] NUM_CH_W   = CWP'(NUM_CH);
    localparam logic [AW:0] MAX_ADDR_W = AWP'(MAX_ADDR);

    // ---------------- per-channel unpacking ----------------
    logic [AW-1:0]         ch_addr  [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_wdata [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_addr[gi]  = i_addr[gi*AW +: AW];
            assign ch_wdata[gi] = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // ---------------- state ----------------
    logic [CW-1:0]               rr_ptr_q, rr_ptr_d;
    logic                        cs_n_q, cs_n_d;
    logic                        we_n_q, we_n_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [NUM_CH-1:0]           wdone_q, wdone_d;
    logic [NUM_CH-1:0]           werr_q, werr_d;
    logic [NUM_CH-1:0]           rvalid_q, rvalid_d;
    logic [NUM_CH-1:0]           rerr_q, rerr_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
    // Read-tracking pipeline: stage 0 is loaded together with the SRAM pins,
    // stage RD_LATENCY lines up with valid i_sram_rdata.
    logic [RD_LATENCY:0]         pipe_vld_q, pipe_vld_d;
    logic [RD_LATENCY:0]         pipe_err_q, pipe_err_d;
    logic [RD_LATENCY:0][CW-1:0] pipe_ch_q, pipe_ch_d;

    // ---------------- arbitration ----------------
    logic          gnt_found;
    logic [CW-1:0] gnt_idx;
    logic [CW:0]   cand;

    // Scan NUM_CH candidates; in round-robin mode the scan starts at the
    // pointer and wraps, in fixed mode it starts at channel 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ARB_MODE == 1) begin
                cand = CWP'(i);
            end else begin
                cand = {1'b0, rr_ptr_q} + CWP'(i);
                if (cand >= NUM_CH_W) begin
                    cand = cand - NUM_CH_W;
                end
            end
            if (!gnt_found && i_req[cand[CW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        if (gnt_found) begin
            o_gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_found) begin
            rr_ptr_d = (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ---------------- selected access ----------------
    logic                  sel_we;
    logic [AW-1:0]         sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_oor;

    assign sel_we    = i_we[gnt_idx];
    assign sel_addr  = ch_addr[gnt_idx];
    assign sel_wdata = ch_wdata[gnt_idx];
    // Only reachable when MAX_ADDR is not a power of two.
    assign sel_oor   = ({1'b0, sel_addr} >= MAX_ADDR_W);

    // ---------------- issue stage ----------------
    always_comb begin
        cs_n_d  = 1'b1;
        we_n_d  = 1'b1;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wdone_d = '0;
        werr_d  = '0;
        // Out-of-range accesses are accepted but never reach the macro.
        if (gnt_found && !sel_oor) begin
            cs_n_d = 1'b0;
            we_n_d = ~sel_we;
            addr_d = sel_addr;
            if (sel_we) begin
                wdata_d = sel_wdata;
            end
        end
        if (gnt_found && sel_we) begin
            wdone_d[gnt_idx] = 1'b1;
            werr_d[gnt_idx]  = sel_oor;
        end
    end

    // ---------------- read pipeline ----------------
    always_comb begin
        pipe_vld_d    = '0;
        pipe_err_d    = '0;
        pipe_ch_d     = '0;
        pipe_vld_d[0] = gnt_found & ~sel_we;
        pipe_err_d[0] = sel_oor;
        pipe_ch_d[0]  = gnt_idx;
        for (int s = 1; s <= RD_LATENCY; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_err_d[s] = pipe_err_q[s-1];
            pipe_ch_d[s]  = pipe_ch_q[s-1];
        end
    end

    // ---------------- response stage ----------------
    always_comb begin
        rvalid_d = '0;
        rerr_d   = '0;
        rdata_d  = rdata_q;
        if (pipe_vld_q[RD_LATENCY]) begin
            rvalid_d[pipe_ch_q[RD_LATENCY]] = 1'b1;
            rerr_d[pipe_ch_q[RD_LATENCY]]   = pipe_err_q[RD_LATENCY];
            // A dropped (out-of-range) read returns zero, not stale bus data.
            rdata_d = pipe_err_q[RD_LATENCY] ? '0 : i_sram_rdata;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q   <= '0;
            cs_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            wdone_q    <= '0;
            werr_q     <= '0;
            rvalid_q   <= '0;
            rerr_q     <= '0;
            rdata_q    <= '0;
            pipe_vld_q <= '0;
            pipe_err_q <= '0;
            pipe_ch_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cs_n_q     <= cs_n_d;
            we_n_q     <= we_n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wdone_q    <= wdone_d;
            werr_q     <= werr_d;
            rvalid_q   <= rvalid_d;
            rerr_q     <= rerr_d;
            rdata_q    <= rdata_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_err_q <= pipe_err_d;
            pipe_ch_q  <= pipe_ch_d;
        end
    end

    // ---------------- outputs ----------------
    assign o_sram_cs_n  = cs_n_q;
    assign o_sram_we_n  = we_n_q;
    assign o_sram_addr  = addr_q;
    assign o_sram_wdata = wdata_q;
    assign o_wdone      = wdone_q;
    assign o_rvalid     = rvalid_q;
    assign o_rdata      = rdata_q;
    assign o_err        = rerr_q | werr_q;
    assign o_busy       = |pipe_vld_q;

endmodule

// File: tb/tb_sram_mp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_mp_arbiter
//   Directed bench for sram_mp_arbiter. Two instances:
//     dut_a : round-robin, RD_LATENCY=1, MAX_ADDR=100 (out-of-range reachable)
//     dut_b : fixed priority, RD_LATENCY=3, MAX_ADDR=128
//   Each instance has a behavioural SRAM macro model. Inputs are driven at the
//   falling edge and all outputs are sampled 1ns later, away from the rising
//   edge.
// ---------------------------------------------------------------------------
module tb_sram_mp_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // ---------------- instance A ----------------
    logic [3:0]   req_a, we_a, gnt_a, rvalid_a, wdone_a, err_a;
    logic [27:0]  addr_a;
    logic [127:0] wdata_a;
    logic [31:0]  rdata_a, swdata_a, srdata_a;
    logic         busy_a, cs_a, we_n_a;
    logic [6:0]   saddr_a;

    sram_mp_arbiter #(
        .NUM_CH(4), .DATA_WIDTH(32), .MAX_ADDR(100), .RD_LATENCY(1), .ARB_MODE(0)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req(req_a), .i_we(we_a), .i_addr(addr_a), .i_wdata(wdata_a),
        .o_gnt(gnt_a), .o_rvalid(rvalid_a), .o_rdata(rdata_a), .o_wdone(wdone_a),
        .o_err(err_a), .o_busy(busy_a),
        .o_sram_cs_n(cs_a), .o_sram_we_n(we_n_a), .o_sram_addr(saddr_a),
        .o_sram_wdata(swdata_a), .i_sram_rdata(srdata_a)
    );

    // SRAM model A: one cycle from sampled pins to data.
    logic [31:0] mem_a [0:127];
    always @(posedge clk) begin
        if (!cs_a && !we_n_a) mem_a[saddr_a] <= swdata_a;
        if (!cs_a && we_n_a)  srdata_a <= mem_a[saddr_a];
    end

    // ---------------- instance B ----------------
    logic [3:0]   req_b, we_b, gnt_b, rvalid_b, wdone_b, err_b;
    logic [27:0]  addr_b;
    logic [127:0] wdata_b;
    logic [31:0]  rdata_b, swdata_b, srdata_b;
    logic         busy_b, cs_b, we_n_b;
    logic [6:0]   saddr_b;

    sram_mp_arbiter #(
        .NUM_CH(4), .DATA_WIDTH(32), .MAX_ADDR(128), .RD_LATENCY(3), .ARB_MODE(1)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req(req_b), .i_we(we_b), .i_addr(addr_b), .i_wdata(wdata_b),
        .o_gnt(gnt_b), .o_rvalid(rvalid_b), .o_rdata(rdata_b), .o_wdone(wdone_b),
        .o_err(err_b), .o_busy(busy_b),
        .o_sram_cs_n(cs_b), .o_sram_we_n(we_n_b), .o_sram_addr(saddr_b),
        .o_sram_wdata(swdata_b), .i_sram_rdata(srdata_b)
    );

    // SRAM model B: three cycles from sampled pins to data.
    logic [31:0] mem_b [0:127];
    logic [31:0] srd_b0, srd_b1, srd_b2;
    always @(posedge clk) begin
        if (!cs_b && !we_n_b) mem_b[saddr_b] <= swdata_b;
        if (!cs_b && we_n_b)  srd_b0 <= mem_b[saddr_b];
        srd_b1 <= srd_b0;
        srd_b2 <= srd_b1;
    end
    assign srdata_b = srd_b2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    task automatic drive_a(input int ch, input logic we, input logic [6:0] addr,
                           input logic [31:0] data);
        req_a[ch]            = 1'b1;
        we_a[ch]             = we;
        addr_a[ch*7 +: 7]    = addr;
        wdata_a[ch*32 +: 32] = data;
    endtask

    task automatic drive_b(input int ch, input logic we, input logic [6:0] addr,
                           input logic [31:0] data);
        req_b[ch]            = 1'b1;
        we_b[ch]             = we;
        addr_b[ch*7 +: 7]    = addr;
        wdata_b[ch*32 +: 32] = data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (cs_a !== 1'b1) begin bad++; $display("FAIL rst_cs_n: got %b want 1", cs_a); end
        total++; if (we_n_a !== 1'b1) begin bad++; $display("FAIL rst_we_n: got %b want 1", we_n_a); end
        total++; if (saddr_a !== 7'd0) begin bad++; $display("FAIL rst_addr: got %0d want 0", saddr_a); end
        total++; if (swdata_a !== 32'd0) begin bad++; $display("FAIL rst_wdata: got %h want 0", swdata_a); end
        total++; if (rdata_a !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata_a); end
        total++; if ({rvalid_a, wdone_a, err_a, busy_a} !== 13'd0) begin bad++;
            $display("FAIL rst_flags: got rv=%b wd=%b er=%b busy=%b want all 0", rvalid_a, wdone_a, err_a, busy_a); end
        total++; if ({cs_b, we_n_b, busy_b} !== 3'b110) begin bad++;
            $display("FAIL rst_b: got cs=%b we=%b busy=%b want 1 1 0", cs_b, we_n_b, busy_b); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if ({gnt_a, rvalid_a, wdone_a, err_a, busy_a, cs_a} !== 18'd1) begin bad++;
            $display("FAIL idle_a: got gnt=%b rv=%b wd=%b er=%b busy=%b cs=%b want idle", gnt_a, rvalid_a, wdone_a, err_a, busy_a, cs_a); end
        $display("test_reset: done");
    endtask

    task automatic test_write_read;
        // write ch0 addr 5 = A5
        @(negedge clk);
        drive_a(0, 1'b1, 7'd5, 32'hA5);
        #1;
        total++; if (gnt_a !== 4'b0001) begin bad++; $display("FAIL wr_gnt: got %b want 0001", gnt_a); end
        // next cycle: write issued; read ch0 addr 5 granted immediately
        @(negedge clk);
        drive_a(0, 1'b0, 7'd5, 32'h0);
        #1;
        total++; if (wdone_a !== 4'b0001) begin bad++; $display("FAIL wr_done: got %b want 0001", wdone_a); end
        total++; if ({cs_a, we_n_a, saddr_a, swdata_a} !== {1'b0, 1'b0, 7'd5, 32'hA5}) begin bad++;
            $display("FAIL wr_pins: got cs=%b we=%b a=%0d d=%h want 0 0 5 a5", cs_a, we_n_a, saddr_a, swdata_a); end
        total++; if (gnt_a !== 4'b0001) begin bad++; $display("FAIL rd_gnt: got %b want 0001", gnt_a); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) req_a = 4'b0000;
            #1;
            if (k == 1) begin
                total++; if ({cs_a, we_n_a, saddr_a} !== {1'b0, 1'b1, 7'd5}) begin bad++;
                    $display("FAIL rd_pins: got cs=%b we=%b a=%0d want 0 1 5", cs_a, we_n_a, saddr_a); end
                total++; if (wdone_a !== 4'b0000) begin bad++; $display("FAIL wr_done_pulse: got %b want 0000", wdone_a); end
            end
            if (k == 3) begin
                total++; if (rvalid_a !== 4'b0001) begin bad++; $display("FAIL rd_valid: got %b want 0001", rvalid_a); end
                total++; if (rdata_a !== 32'hA5) begin bad++; $display("FAIL rd_data: got %h want a5", rdata_a); end
                total++; if (err_a !== 4'b0000) begin bad++; $display("FAIL rd_err: got %b want 0000", err_a); end
            end else begin
                total++; if (rvalid_a !== 4'b0000) begin bad++; $display("FAIL rd_valid_k%0d: got %b want 0000", k, rvalid_a); end
            end
            if (k == 4) begin
                total++; if (rdata_a !== 32'hA5) begin bad++; $display("FAIL rd_hold: got %h want a5", rdata_a); end
            end
        end
        $display("test_write_read: done");
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_v;
        logic [31:0] exp_d;
        int          idx;
        // preload addr 10+c with 0x100+c from each channel in turn
        we_a = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_a = 4'b0000;
            drive_a(c, 1'b1, 7'(10 + c), 32'h100 + 32'(c));
            #1;
            exp_v = 4'b0001 << c;
            total++; if (gnt_a !== exp_v) begin bad++; $display("FAIL rr_pre_gnt%0d: got %b want %b", c, gnt_a, exp_v); end
        end
        // all four read continuously
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 0) begin
                for (int c = 0; c < 4; c++) drive_a(c, 1'b0, 7'(10 + c), 32'h0);
            end
            if (k == 8) req_a = 4'b0000;
            #1;
            if (k < 8) begin
                exp_v = 4'b0001 << (k % 4);
                total++; if (gnt_a !== exp_v) begin bad++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt_a, exp_v); end
            end
            if (k >= 3) begin
                idx   = (k - 3) % 4;
                exp_v = 4'b0001 << idx;
                exp_d = 32'h100 + 32'(idx);
                total++; if (rvalid_a !== exp_v) begin bad++; $display("FAIL rr_rvalid%0d: got %b want %b", k, rvalid_a, exp_v); end
                total++; if (rdata_a !== exp_d) begin bad++; $display("FAIL rr_rdata%0d: got %h want %h", k, rdata_a, exp_d); end
            end
        end
        @(negedge clk);
        #1;
        total++; if ({rvalid_a, busy_a} !== 5'd0) begin bad++; $display("FAIL rr_drain: got rv=%b busy=%b want 0", rvalid_a, busy_a); end
        $display("test_round_robin: done");
    endtask

    task automatic test_fixed_priority;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) begin
                drive_b(1, 1'b1, 7'd1, 32'h11);
                drive_b(3, 1'b1, 7'd3, 32'h33);
            end
            if (k == 4) req_b[1] = 1'b0;
            if (k == 5) begin
                req_b[3] = 1'b0;
                drive_b(2, 1'b1, 7'd2, 32'h22);
            end
            if (k == 6) req_b = 4'b0000;
            #1;
            if (k < 4) begin
                total++; if (gnt_b !== 4'b0010) begin bad++; $display("FAIL fp_gnt%0d: got %b want 0010", k, gnt_b); end
            end
            if (k >= 1 && k <= 4) begin
                total++; if (wdone_b !== 4'b0010) begin bad++; $display("FAIL fp_wdone%0d: got %b want 0010", k, wdone_b); end
            end
            if (k == 4) begin
                total++; if (gnt_b !== 4'b1000) begin bad++; $display("FAIL fp_ch3_gnt: got %b want 1000", gnt_b); end
            end
            if (k == 5) begin
                total++; if (wdone_b !== 4'b1000) begin bad++; $display("FAIL fp_ch3_wdone: got %b want 1000", wdone_b); end
                total++; if (gnt_b !== 4'b0100) begin bad++; $display("FAIL fp_ch2_gnt: got %b want 0100", gnt_b); end
            end
            if (k == 6) begin
                total++; if (gnt_b !== 4'b0000) begin bad++; $display("FAIL fp_idle_gnt: got %b want 0000", gnt_b); end
            end
        end
        $display("test_fixed_priority: done");
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_d;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (j < 3) drive_b(2, 1'b0, 7'(j + 1), 32'h0);
            if (j == 3) req_b = 4'b0000;
            #1;
            if (j < 3) begin
                total++; if (gnt_b !== 4'b0100) begin bad++; $display("FAIL b2b_gnt%0d: got %b want 0100", j, gnt_b); end
            end
            if (j >= 5 && j <= 7) begin
                exp_d = 32'h11 * 32'(j - 4);
                total++; if (rvalid_b !== 4'b0100) begin bad++; $display("FAIL b2b_rvalid%0d: got %b want 0100", j, rvalid_b); end
                total++; if (rdata_b !== exp_d) begin bad++; $display("FAIL b2b_rdata%0d: got %h want %h", j, rdata_b, exp_d); end
            end else begin
                total++; if (rvalid_b !== 4'b0000) begin bad++; $display("FAIL b2b_rvalid%0d: got %b want 0000", j, rvalid_b); end
            end
            if (j == 1 || j == 6) begin
                total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL b2b_busy%0d: got %b want 1", j, busy_b); end
            end
            if (j == 8) begin
                total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", busy_b); end
            end
        end
        $display("test_back_to_back: done");
    endtask

    task automatic test_reset_inflight;
        @(negedge clk);
        drive_a(0, 1'b0, 7'd10, 32'h0);
        #1;
        total++; if (gnt_a !== 4'b0001) begin bad++; $display("FAIL ri_gnt0: got %b want 0001", gnt_a); end
        @(negedge clk);
        drive_a(0, 1'b0, 7'd11, 32'h0);
        #1;
        total++; if (gnt_a !== 4'b0001) begin bad++; $display("FAIL ri_gnt1: got %b want 0001", gnt_a); end
        @(negedge clk);
        req_a = 4'b0000;
        #1;
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL ri_busy: got %b want 1", busy_a); end
        rst_n = 1'b0;
        #1;
        total++; if ({busy_a, rvalid_a, cs_a} !== 6'b000001) begin bad++;
            $display("FAIL ri_async: got busy=%b rv=%b cs=%b want 0 0000 1", busy_a, rvalid_a, cs_a); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            total++; if (rvalid_a !== 4'b0000) begin bad++; $display("FAIL ri_ghost%0d: got %b want 0000", k, rvalid_a); end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) drive_a(2, 1'b0, 7'd12, 32'h0);
            if (k == 1) req_a = 4'b0000;
            #1;
            if (k == 0) begin
                total++; if (gnt_a !== 4'b0100) begin bad++; $display("FAIL ri_post_gnt: got %b want 0100", gnt_a); end
            end
            if (k == 3) begin
                total++; if (rvalid_a !== 4'b0100) begin bad++; $display("FAIL ri_post_rvalid: got %b want 0100", rvalid_a); end
                total++; if (rdata_a !== 32'h102) begin bad++; $display("FAIL ri_post_rdata: got %h want 102", rdata_a); end
            end
        end
        $display("test_reset_inflight: done");
    endtask

    task automatic test_out_of_range;
        // read addr 120 (>= 100)
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) drive_a(1, 1'b0, 7'd120, 32'h0);
            if (k == 1) req_a = 4'b0000;
            #1;
            if (k == 0) begin
                total++; if (gnt_a !== 4'b0010) begin bad++; $display("FAIL oor_rd_gnt: got %b want 0010", gnt_a); end
            end
            if (k == 1) begin
                total++; if (cs_a !== 1'b1) begin bad++; $display("FAIL oor_rd_cs: got %b want 1", cs_a); end
            end
            if (k == 3) begin
                total++; if (rvalid_a !== 4'b0010) begin bad++; $display("FAIL oor_rd_rvalid: got %b want 0010", rvalid_a); end
                total++; if (err_a !== 4'b0010) begin bad++; $display("FAIL oor_rd_err: got %b want 0010", err_a); end
                total++; if (rdata_a !== 32'd0) begin bad++; $display("FAIL oor_rd_data: got %h want 0", rdata_a); end
            end else begin
                total++; if ({rvalid_a, err_a} !== 8'd0) begin bad++; $display("FAIL oor_rd_quiet%0d: got rv=%b er=%b want 0", k, rvalid_a, err_a); end
            end
        end
        // write addr 110 (>= 100): dropped, done+err next cycle
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) drive_a(1, 1'b1, 7'd110, 32'hDEAD);
            if (k == 1) req_a = 4'b0000;
            #1;
            if (k == 0) begin
                total++; if (gnt_a !== 4'b0010) begin bad++; $display("FAIL oor_wr_gnt: got %b want 0010", gnt_a); end
            end
            if (k == 1) begin
                total++; if (wdone_a !== 4'b0010) begin bad++; $display("FAIL oor_wr_done: got %b want 0010", wdone_a); end
                total++; if (err_a !== 4'b0010) begin bad++; $display("FAIL oor_wr_err: got %b want 0010", err_a); end
                total++; if (cs_a !== 1'b1) begin bad++; $display("FAIL oor_wr_cs: got %b want 1", cs_a); end
            end
            if (k == 2) begin
                total++; if ({wdone_a, err_a} !== 8'd0) begin bad++; $display("FAIL oor_wr_pulse: got wd=%b er=%b want 0", wdone_a, err_a); end
            end
        end
        $display("test_out_of_range: done");
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        req_a   = '0; we_a = '0; addr_a = '0; wdata_a = '0;
        req_b   = '0; we_b = '0; addr_b = '0; wdata_b = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_priority();
        test_back_to_back();
        test_reset_inflight();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
